// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port matrix storage RAM between the
// input writer (0), the calculator (1) and the display reader (2).
// The grant is registered and round-robin. An owner holding its lock bit keeps
// the port. An unlocked owner gives way after MAX_BURST beats when someone else waits.
// Optional build macro: ARB_STATS_EN adds the stall_cnt statistics output.

module mem_port_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                sys_rst,
   input  logic [2:0]          req,
   input  logic [2:0]          lock,
   input  logic [2:0]          we,
   input  logic [3*ADDR_W-1:0] addr,
   input  logic [3*DATA_W-1:0] wdata,
   output logic [2:0]          gnt,
   output logic [2:0]          rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]         stall_cnt
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   // One-hot state encoding so that the state register is the grant itself
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      OWN0 = 3'b001,
      OWN1 = 3'b010,
      OWN2 = 3'b100
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [1:0]         last_owner;
   logic [1:0]         own_idx;
   logic [CNT_W-1:0]   beat_cnt;
   logic [CNT_W-1:0]   beat_cnt_inc;
   logic [2:0]         beat_vec;
   logic [2:0]         others;
   logic [2:0]         pick;
   logic               beat;
   logic               grant_change;
   logic               owner_left;
   logic               own_we;
   logic [ADDR_W-1:0]  own_addr;
   logic [DATA_W-1:0]  own_wdata;
   logic [ADDR_W-1:0]  addr_hold;
   logic [DATA_W-1:0]  wdata_hold;

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Returns {found, index} of the first candidate at or after start (mod 3)
   function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] start);
      logic [1:0] i0;
      logic [1:0] i1;
      logic [1:0] i2;
      i0 = start;
      i1 = next_idx(i0);
      i2 = next_idx(i1);
      if (cand[i0])      return {1'b1, i0};
      else if (cand[i1]) return {1'b1, i1};
      else if (cand[i2]) return {1'b1, i2};
      else               return 3'b000;
   endfunction

   function automatic state_t own_state(input logic [1:0] idx);
      case (idx)
         2'd0:    return OWN0;
         2'd1:    return OWN1;
         default: return OWN2;
      endcase
   endfunction

   assign gnt          = state;
   assign beat_vec     = gnt & req;
   assign beat         = |beat_vec;
   assign others       = req & ~gnt;
   assign beat_cnt_inc = (beat_cnt == BURST_LIM) ? beat_cnt : beat_cnt + CNT_W'(1);
   assign rdata        = mem_rdata;

   // Decode the current owner and select its request fields
   always_comb begin
      own_idx   = 2'd0;
      own_we    = we[0];
      own_addr  = addr[0 +: ADDR_W];
      own_wdata = wdata[0 +: DATA_W];
      case (state)
         OWN1: begin
            own_idx   = 2'd1;
            own_we    = we[1];
            own_addr  = addr[ADDR_W +: ADDR_W];
            own_wdata = wdata[DATA_W +: DATA_W];
         end
         OWN2: begin
            own_idx   = 2'd2;
            own_we    = we[2];
            own_addr  = addr[2*ADDR_W +: ADDR_W];
            own_wdata = wdata[2*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

   // Next grant: first pick from idle, release on req drop, or starvation preemption
   always_comb begin
      next_state   = state;
      grant_change = 1'b0;
      owner_left   = 1'b0;
      pick         = 3'b000;
      if (state == IDLE) begin
         if (|req) begin
            pick         = rr_pick(req, next_idx(last_owner));
            next_state   = own_state(pick[1:0]);
            grant_change = 1'b1;
         end
      end else if (!beat) begin
         pick         = rr_pick(others, next_idx(own_idx));
         owner_left   = 1'b1;
         grant_change = 1'b1;
         next_state   = pick[2] ? own_state(pick[1:0]) : IDLE;
      end else if ((beat_cnt_inc == BURST_LIM) && !lock[own_idx] && (|others)) begin
         pick         = rr_pick(others, next_idx(own_idx));
         owner_left   = 1'b1;
         grant_change = 1'b1;
         next_state   = own_state(pick[1:0]);
      end
   end

   // Grant state, round-robin pointer and burst length counter
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         last_owner <= 2'd2;
         beat_cnt   <= '0;
      end else begin
         state <= next_state;
         if (owner_left)
            last_owner <= own_idx;
         if (grant_change)
            beat_cnt <= '0;
         else if (beat)
            beat_cnt <= beat_cnt_inc;
      end
   end

   // Remember the last beat's address/data and flag reads for the next cycle
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         addr_hold  <= '0;
         wdata_hold <= '0;
         rvalid     <= 3'b000;
      end else begin
         rvalid <= beat_vec & ~we;
         if (beat) begin
            addr_hold  <= own_addr;
            wdata_hold <= own_wdata;
         end
      end
   end

   // Storage port: owner's fields pass through during a beat, otherwise hold
   always_comb begin
      mem_we    = beat & own_we;
      mem_addr  = addr_hold;
      mem_wdata = wdata_hold;
      if (beat) begin
         mem_addr  = own_addr;
         mem_wdata = own_wdata;
      end
   end

`ifdef ARB_STATS_EN
   // Count cycles in which any requester waits without the grant
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst)
         stall_cnt <= 16'h0000;
      else if ((|(req & ~gnt)) && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'h0001;
   end
`endif

endmodule
